// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick / square-wave generator with pause and re-phase.
// Optional square-wave outputs are built only when TICK_GEN_SQ_OUT_EN is defined.
module tick_gen_multi #(
  parameter int NCH = 5,
  parameter int CNT_W = 26,
  parameter logic [NCH*CNT_W-1:0] DIV_INIT = {26'd50000000, 26'd5000000, 26'd500000, 26'd250000, 26'd50000},
  localparam int CH_W = (NCH > 32'sd1) ? $clog2(NCH) : 32'sd1
) (
  input  logic             clk_50MHz,
  input  logic             rst,
  input  logic             run,
  input  logic             restart,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_div,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   sq
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] div_r      [NCH];
  logic [CNT_W-1:0] cnt_r      [NCH];
  logic [NCH-1:0]   tick_r;

  logic [CNT_W-1:0] eff_div_s  [NCH];
  logic [CNT_W-1:0] cnt_inc_s  [NCH];
  logic [CNT_W-1:0] div_nxt_s  [NCH];
  logic [CNT_W-1:0] cnt_nxt_s  [NCH];
  logic [NCH-1:0]   wr_hit_s;
  logic [NCH-1:0]   wrap_s;
  logic [NCH-1:0]   tick_nxt_s;

  // Per-channel effective divisor, write decode and counter increment.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      eff_div_s[i] = (div_r[i] == '0) ? ONE : div_r[i];
      wr_hit_s[i]  = wr_en && (wr_ch == CH_W'(i));
      // >= keeps the counter bounded even if it were ever above D-1
      wrap_s[i]    = (cnt_r[i] >= (eff_div_s[i] - ONE));
      cnt_inc_s[i] = wrap_s[i] ? '0 : (cnt_r[i] + ONE);
    end
  end

  // Next-state selection: restart > write > run/pause.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      div_nxt_s[i]  = div_r[i];
      cnt_nxt_s[i]  = cnt_r[i];
      tick_nxt_s[i] = 1'b0;
      if (restart) begin
        cnt_nxt_s[i] = '0;
      end else if (wr_hit_s[i]) begin
        div_nxt_s[i] = wr_div;
        cnt_nxt_s[i] = '0;
      end else if (run) begin
        cnt_nxt_s[i]  = cnt_inc_s[i];
        tick_nxt_s[i] = wrap_s[i];
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
  end

  // Divisor, counter and tick registers.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        div_r[i] <= DIV_INIT[i*CNT_W +: CNT_W];
        cnt_r[i] <= '0;
      end
      tick_r <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        div_r[i] <= div_nxt_s[i];
        cnt_r[i] <= cnt_nxt_s[i];
      end
      tick_r <= tick_nxt_s;
    end
  end

  assign tick = tick_r;

`ifdef TICK_GEN_SQ_OUT_EN
  logic [CNT_W-1:0] wr_eff_s;
  logic [NCH-1:0]   sq_r;
  logic [NCH-1:0]   sq_nxt_s;

  // Square-wave level: high while the new count is below half the divisor.
  always_comb begin
    wr_eff_s = (wr_div == '0) ? ONE : wr_div;
    for (int i = 0; i < NCH; i++) begin
      sq_nxt_s[i] = sq_r[i];
      if (restart) begin
        sq_nxt_s[i] = (eff_div_s[i] > ONE);
      end else if (wr_hit_s[i]) begin
        sq_nxt_s[i] = (wr_eff_s > ONE);
      end else if (run) begin
        sq_nxt_s[i] = (cnt_inc_s[i] < (eff_div_s[i] >> 1));
      end else begin
        sq_nxt_s[i] = sq_r[i];
      end
    end
  end

  // Square-wave output register.
  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      sq_r <= '0;
    end else begin
      sq_r <= sq_nxt_s;
    end
  end

  assign sq = sq_r;
`else
  assign sq = '0;
`endif

endmodule
